// File: rtl/reg_piso_serializer.sv
// rtl/reg_piso_serializer.sv - MSB-first parallel-in/serial-out stream with frame-end marker.
// Optional SERIAL_PARITY_EN appends an even-parity beat after the data bits.
module reg_piso_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last
);

`ifdef SERIAL_PARITY_EN
    localparam int BEATS = WIDTH + 1;
`else
    localparam int BEATS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BEATS-1:0] shift_reg;
    logic [BEATS-1:0] load_word;
    logic [CW-1:0]    cnt;
    logic             load_fire;
    logic             beat_fire;

    // The parity bit rides at the bottom of the shift register so it leaves right after the data.
`ifdef SERIAL_PARITY_EN
    assign load_word = {load_data, ^load_data};
`else
    assign load_word = load_data;
`endif

    assign load_fire = (state == IDLE) && load_valid;
    assign beat_fire = ser_valid && ser_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        ser_out    = shift_reg[BEATS-1];
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_last  = (cnt == LAST_CNT);
                if (ser_ready && ser_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Zero fill leaves the register clear after a frame, so ser_out idles low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (load_fire) begin
            shift_reg <= load_word;
            cnt       <= '0;
        end else if (beat_fire) begin
            shift_reg <= {shift_reg[BEATS-2:0], 1'b0};
            cnt       <= ser_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_reg_piso_serializer.sv
// tb/tb_reg_piso_serializer.sv - directed self-checking bench for reg_piso_serializer.
module tb_reg_piso_serializer;

`ifdef SERIAL_PARITY_EN
    localparam int BEATS = 33;
`else
    localparam int BEATS = 32;
`endif

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        ser_valid;
    logic        ser_ready;
    logic        ser_out;
    logic        ser_last;

    int checks;
    int failures;

    reg_piso_serializer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_out    (ser_out),
        .ser_last   (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat i of a frame: data bits MSB first, then (with parity) the even-parity bit.
    function automatic logic exp_bit(input logic [31:0] w, input int i);
        if (i < 32) return w[31-i];
        return ^w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        ser_ready  = 1'b0;
        #2;
        checks++;
        if ({ser_valid, ser_out, ser_last, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_asserted got=%b want=0001", {ser_valid, ser_out, ser_last, load_ready});
        end
        #18;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({ser_valid, ser_out, ser_last, load_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%b want=0001", c, {ser_valid, ser_out, ser_last, load_ready});
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] pat;
        logic       want;
        pat       = 8'b1010_1111;
        ser_ready = 1'b1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_load_ready got=%b want=1", load_ready);
        end
        do_load(32'hAFAF_AFAF);
        for (int i = 0; i < BEATS; i++) begin
            want = (i < 32) ? pat[7 - (i % 8)] : 1'b0;
            checks++;
            if ({ser_valid, ser_out, ser_last} !== {1'b1, want, (i == BEATS - 1)}) begin
                failures++;
                $display("FAIL basic_beat i=%0d got v/o/l=%b want=%b", i, {ser_valid, ser_out, ser_last}, {1'b1, want, (i == BEATS - 1)});
            end
            step();
        end
        checks++;
        if ({ser_valid, ser_last, load_ready} !== 3'b001) begin
            failures++;
            $display("FAIL basic_end got v/l/r=%b want=001", {ser_valid, ser_last, load_ready});
        end
    endtask

    task automatic test_backpressure();
        ser_ready = 1'b1;
        do_load(32'h8000_0001);
        for (int i = 0; i < BEATS; i++) begin
            if (i == 10) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checks++;
                    if ({ser_valid, ser_out, ser_last, load_ready} !== 4'b1000) begin
                        failures++;
                        $display("FAIL stall_hold s=%0d got=%b want=1000", s, {ser_valid, ser_out, ser_last, load_ready});
                    end
                end
                ser_ready = 1'b1;
            end
            checks++;
            if ({ser_valid, ser_out, ser_last} !== {1'b1, exp_bit(32'h8000_0001, i), (i == BEATS - 1)}) begin
                failures++;
                $display("FAIL bp_beat i=%0d got=%b want=%b", i, {ser_valid, ser_out, ser_last}, {1'b1, exp_bit(32'h8000_0001, i), (i == BEATS - 1)});
            end
            step();
        end
        checks++;
        if ({ser_valid, load_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_end got v/r=%b want=01", {ser_valid, load_ready});
        end
    endtask

    task automatic test_load_during_shift();
        logic want;
        ser_ready = 1'b1;
        do_load(32'hFFFF_0000);
        for (int i = 0; i < BEATS; i++) begin
            if (i == 4) begin
                load_valid = 1'b1;
                load_data  = 32'h1234_5678;
                checks++;
                if (load_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_load_ready got=%b want=0", load_ready);
                end
            end else begin
                load_valid = 1'b0;
            end
            want = (i < 16) ? 1'b1 : 1'b0;
            checks++;
            if ({ser_valid, ser_out, ser_last} !== {1'b1, want, (i == BEATS - 1)}) begin
                failures++;
                $display("FAIL busy_beat i=%0d got=%b want=%b", i, {ser_valid, ser_out, ser_last}, {1'b1, want, (i == BEATS - 1)});
            end
            step();
        end
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({ser_valid, load_ready} !== 2'b01) begin
                failures++;
                $display("FAIL busy_no_queue c=%0d got v/r=%b want=01", c, {ser_valid, load_ready});
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic want;
        ser_ready = 1'b1;
        do_load(32'hAFAF_AFAF);
        repeat (7) step();
        reset = 1'b0;
        #1;
        checks++;
        if ({ser_valid, ser_out, ser_last, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_abort got=%b want=0001", {ser_valid, ser_out, ser_last, load_ready});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        do_load(32'h0000_0003);
        for (int i = 0; i < BEATS; i++) begin
            want = (i == 30 || i == 31) ? 1'b1 : 1'b0;
            checks++;
            if ({ser_valid, ser_out, ser_last} !== {1'b1, want, (i == BEATS - 1)}) begin
                failures++;
                $display("FAIL midreset_beat i=%0d got=%b want=%b", i, {ser_valid, ser_out, ser_last}, {1'b1, want, (i == BEATS - 1)});
            end
            step();
        end
        checks++;
        if ({ser_valid, load_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_end got v/r=%b want=01", {ser_valid, load_ready});
        end
    endtask

`ifdef SERIAL_PARITY_EN
    task automatic test_parity();
        ser_ready = 1'b1;
        do_load(32'h0000_0001);
        for (int i = 0; i < 33; i++) begin
            checks++;
            if ({ser_valid, ser_out, ser_last} !== {1'b1, (i >= 31), (i == 32)}) begin
                failures++;
                $display("FAIL parity_beat i=%0d got=%b want=%b", i, {ser_valid, ser_out, ser_last}, {1'b1, (i >= 31), (i == 32)});
            end
            step();
        end
        checks++;
        if ({ser_valid, load_ready} !== 2'b01) begin
            failures++;
            $display("FAIL parity_end got v/r=%b want=01", {ser_valid, load_ready});
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_load_during_shift();
        test_reset_mid_frame();
`ifdef SERIAL_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
